// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - ID-stage to branch resolver bundle
// The master is the ID stage, which drives the instruction and operands. The slave is the resolver.
interface branch_resolve_unit_if #(
  parameter int PC_W  = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_adv;
  logic [6:0]       id_op;
  logic [2:0]       id_funct3;
  logic [PC_W-1:0]  id_pc;
  logic [PC_W-1:0]  id_imm;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             opnd_rdy;
  logic             flush;
  logic             b_eval;
  logic             branch_outcome;
  logic             trgt_gen;
  logic [PC_W-1:0]  alupc;
  logic [PC_W-1:0]  pcplf;
  logic             jr_bpu;
  logic [PC_W-1:0]  jr_in;
  logic             stall_req;
  logic [CNT_W-1:0] cnt_br;
  logic [CNT_W-1:0] cnt_tk;
  logic [CNT_W-1:0] cnt_jmp;
  logic [CNT_W-1:0] cnt_stall;

  modport master (
    output id_valid, id_adv, id_op, id_funct3, id_pc, id_imm,
           rs1_val, rs2_val, opnd_rdy, flush,
    input  b_eval, branch_outcome, trgt_gen, alupc, pcplf, jr_bpu, jr_in,
           stall_req, cnt_br, cnt_tk, cnt_jmp, cnt_stall
  );

  modport slave (
    input  id_valid, id_adv, id_op, id_funct3, id_pc, id_imm,
           rs1_val, rs2_val, opnd_rdy, flush,
    output b_eval, branch_outcome, trgt_gen, alupc, pcplf, jr_bpu, jr_in,
           stall_req, cnt_br, cnt_tk, cnt_jmp, cnt_stall
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - decode-stage branch/jump resolver
// Produces exactly one resolve pulse per control-flow instruction, stalls for operands, and keeps saturating counters.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  branch_resolve_unit_if.slave bif
);
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_tk_q, cnt_tk_d;
  logic [CNT_W-1:0] cnt_jmp_q, cnt_jmp_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic            is_b, is_jal, is_jalr, ctl;
  logic            resolve, stall, cond;
  logic [PC_W-1:0] jr_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != {CNT_W{1'b1}}) ? v + 1'b1 : v;
  endfunction

  assign is_b    = bif.id_op == OP_B;
  assign is_jal  = bif.id_op == OP_JAL;
  assign is_jalr = bif.id_op == OP_JALR;
  assign ctl     = bif.id_valid & ~bif.flush & (is_b | is_jal | is_jalr);

  always_comb begin
    cond = 1'b0;
    case (bif.id_funct3)
      3'b000:  cond = bif.rs1_val == bif.rs2_val;
      3'b001:  cond = bif.rs1_val != bif.rs2_val;
      3'b100:  cond = $signed(bif.rs1_val) <  $signed(bif.rs2_val);
      3'b101:  cond = $signed(bif.rs1_val) >= $signed(bif.rs2_val);
      3'b110:  cond = bif.rs1_val <  bif.rs2_val;
      3'b111:  cond = bif.rs1_val >= bif.rs2_val;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    resolve = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (ctl) begin
        if (is_jal || bif.opnd_rdy) begin
          resolve = 1'b1;
          state_d = bif.id_adv ? IDLE : DONE;
        end else begin
          stall   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Losing ctl here means a flush or a vanished instruction, so it is dropped without a resolve.
        if (!ctl) begin
          state_d = IDLE;
        end else if (bif.opnd_rdy) begin
          resolve = 1'b1;
          state_d = bif.id_adv ? IDLE : DONE;
        end else begin
          stall = 1'b1;
        end
      end
      DONE: if (bif.id_adv || bif.flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!nrst) begin
      resolve = 1'b0;
      stall   = 1'b0;
    end
  end

  always_comb begin
    cnt_br_d    = sat_inc(cnt_br_q, resolve & is_b);
    cnt_tk_d    = sat_inc(cnt_tk_q, resolve & is_b & cond);
    cnt_jmp_d   = sat_inc(cnt_jmp_q, resolve & (is_jal | is_jalr));
    cnt_stall_d = sat_inc(cnt_stall_q, stall);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_br_q    <= '0;
      cnt_tk_q    <= '0;
      cnt_jmp_q   <= '0;
      cnt_stall_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_br_q    <= cnt_br_d;
      cnt_tk_q    <= cnt_tk_d;
      cnt_jmp_q   <= cnt_jmp_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign jr_sum             = PC_W'(bif.rs1_val) + bif.id_imm;
  assign bif.alupc          = bif.id_pc + bif.id_imm;
  assign bif.pcplf          = bif.id_pc + PC_W'(4);
  assign bif.jr_in          = {jr_sum[PC_W-1:1], 1'b0};
  assign bif.b_eval         = resolve & is_b;
  assign bif.branch_outcome = resolve & is_b & cond;
  assign bif.trgt_gen       = resolve & (is_b | is_jal);
  assign bif.jr_bpu         = resolve & is_jalr;
  assign bif.stall_req      = stall;
  assign bif.cnt_br         = cnt_br_q;
  assign bif.cnt_tk         = cnt_tk_q;
  assign bif.cnt_jmp        = cnt_jmp_q;
  assign bif.cnt_stall      = cnt_stall_q;
endmodule
